alarm_multi: RTL
================

# alarm_multi

Multi-channel successor to the single-alarm block: holds `N_ALARM` independently settable and enabled alarm times, compares them against the clock's hour/minute bus, and drives one `ring` output. It adds snooze, an automatic ring timeout and ring-source identification. It sits between the time-keeping counter and the user-interface/buzzer logic in the digital clock.

## Interface
- `N_ALARM`, 4: number of alarm channels, 1..8.
- `SNOOZE_MIN`, 5: snooze length in minutes, 1..59.
- `RING_TIMEOUT_MIN`, 3: ring auto-stops after this many minute changes, 1..59.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `time_in` in 11: current time, {hour[10:6], min[5:0]}, binary.
- `time_set_in` in 11: alarm time to store, same format.
- `set_sel` in `$clog2(N_ALARM)` (min 1): channel written by `set_time`.
- `set_time` in 1: one-cycle strobe; stores `time_set_in` into channel `set_sel`.
- `en_in` in `N_ALARM`: per-channel enable, level.
- `end_ring` in 1: one-cycle strobe; stops ringing and cancels any snooze.
- `snooze` in 1: one-cycle strobe; while ringing, defers ringing by `SNOOZE_MIN`.
- `ring` out 1: alarm sounding.
- `ring_id` out `$clog2(N_ALARM)`: channel that caused the current ring or snooze.
- `snoozing` out 1: a snooze is armed.
- `set_err` out 1: one-cycle pulse when a `set_time` is rejected.

## Operation
- Reset: all stored alarm times 00:00, `time_q`=00:00, FSM IDLE, `ring`=0, `ring_id`=0, `snoozing`=0, `set_err`=0, timeout counter 0.
- `time_q` registers `time_in` every cycle; `minute_tick` = (`time_in` != `time_q`), combinational. Any change counts as a tick, including jumps from the user setting the clock.
- Match for channel i: `minute_tick` & `en_in[i]` & (`time_in` == `alarm[i]`). Matching is edge-based, so an alarm fires at most once per minute entry.
- If several channels match in the same cycle, the lowest index wins.
- Set: if `time_set_in` has hour>23 or min>59, the value is not stored and `set_err` pulses. Otherwise `alarm[set_sel]` is written. A write never affects an active ring.
- FSM states IDLE, RING, SNOOZE:
  - IDLE to RING on a match; `ring_id` takes the winning index and the timeout counter clears.
  - RING:
    - `end_ring`: go to IDLE.
    - Else `snooze`: go to SNOOZE; snooze target = `time_in` + `SNOOZE_MIN`.
    - Else a new match from any channel: stay in RING, `ring_id` updates, timeout counter restarts.
    - Else on `minute_tick` the counter increments; when it reaches `RING_TIMEOUT_MIN`, go to IDLE.
    - If `en_in[ring_id]` goes low: go to IDLE.
  - SNOOZE:
    - On a tick where `time_in` == target: go to RING. The counter clears and `ring_id` is kept.
    - On a channel match: go to RING with the new id; the snooze is discarded.
    - `end_ring` or `en_in[ring_id]` low: go to IDLE.
- Snooze arithmetic: min + `SNOOZE_MIN`. If the result is 60 or more, subtract 60 and carry into hour. Hour 24 wraps to 0, so 23:58 + 5 gives 00:03.
- Priority within one cycle: `rst` > `end_ring` > `snooze` > match > timeout.
- Outputs: `ring` = (state==RING); `snoozing` = (state==SNOOZE).

## Timing
- Registered outputs. `ring` rises on the clock edge following the cycle in which `time_in` changes to a matching value, i.e. a 1-cycle latency.
- `end_ring` and `snooze` take effect at the edge that samples them; `ring` is low in the next cycle.
- `set_time` writes at the sampling edge. The new value takes part in the match on any tick from the next cycle onward.
- `set_err` is high for exactly the cycle after the rejected strobe.
- Reset asserted mid-ring or mid-snooze forces every output to its reset value at the next edge.

## Structure
- Shared package `clock_pkg`:
  - `HOUR_W`=5, `MIN_W`=6, `TIME_W`=11.
  - `MIN_PER_HOUR`=60, `HOUR_PER_DAY`=24.
  - FSM state encoding `alarm_state_t` {IDLE, RING, SNOOZE}.
  - Function `time_add_min(time, n)` for wrap-around minute addition.
- Sub-module `alarm_slot`, one per channel:
  - Holds the stored time and performs the write.
  - Outputs `match`.
  - Instantiated via generate.
- Top level holds `time_q`, the priority encoder, the FSM, the timeout counter and the snooze target.

## Test plan
- Single alarm: set ch0=08:30, `en_in`=0001, step time 08:20 to 08:30 → `ring`=1 one cycle after 08:30 appears, `ring_id`=0. `end_ring` → `ring`=0. 08:30 held further → no re-ring.
- Disabled and invalid: ch1=23:55 with `en_in[1]`=0 → no ring at 23:55. Set 24:10 on ch2 → `set_err` pulse, ch2 remains 00:00.
- Simultaneous and override: ch1 and ch3 both 15:45 → `ring_id`=1. While ringing, ch2=15:46 fires → `ring_id`=2, timeout restarts.
- Snooze wrap: ch0=23:58 rings, `snooze` at 23:58 → `snoozing`=1. Ring returns at 00:03 with `ring_id`=0. `end_ring` and `snooze` in the same cycle → IDLE.
- Timeout: ring at 06:00 with no input → `ring` falls at the tick to 06:03 (`RING_TIMEOUT_MIN`=3).
- Reset mid-ring and disable: `rst` while `ring`=1 → all outputs 0 at the next edge. Drop `en_in[ring_id]` while snoozing → `snoozing`=0, no later ring.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day types and helpers for the digital clock blocks.
// Times are packed {hour[10:6], min[5:0]} in plain binary.
package clock_pkg;

  localparam int HOUR_W       = 5;
  localparam int MIN_W        = 6;
  localparam int TIME_W       = 11;
  localparam int MIN_PER_HOUR = 60;
  localparam int HOUR_PER_DAY = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  // Adds n minutes (n < 60), carrying into the hour and wrapping at midnight.
  function automatic logic [TIME_W-1:0] time_add_min(input logic [TIME_W-1:0] t,
                                                     input logic [MIN_W-1:0]  n);
    logic [MIN_W:0]  m;
    logic [HOUR_W:0] h;
    m = {1'b0, t[MIN_W-1:0]} + {1'b0, n};
    h = {1'b0, t[TIME_W-1:MIN_W]};
    if (m >= (MIN_W+1)'(MIN_PER_HOUR)) begin
      m = m - (MIN_W+1)'(MIN_PER_HOUR);
      h = h + (HOUR_W+1)'(1);
    end
    if (h >= (HOUR_W+1)'(HOUR_PER_DAY)) h = h - (HOUR_W+1)'(HOUR_PER_DAY);
    return {h[HOUR_W-1:0], m[MIN_W-1:0]};
  endfunction

  function automatic logic time_valid(input logic [TIME_W-1:0] t);
    return (t[TIME_W-1:MIN_W] < HOUR_W'(HOUR_PER_DAY)) &&
           (t[MIN_W-1:0] < MIN_W'(MIN_PER_HOUR));
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm channel: stored alarm time plus its edge-qualified match.
module alarm_slot
  import clock_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [TIME_W-1:0] wdata,
  input  logic [TIME_W-1:0] time_in,
  input  logic              en,
  input  logic              minute_tick,
  output logic              match
);

  logic [TIME_W-1:0] alarm;

  always_ff @(posedge clk) begin
    if (rst)     alarm <= '0;
    else if (wr) alarm <= wdata;
  end

  assign match = minute_tick & en & (time_in == alarm);

endmodule

// File: rtl/alarm_multi.sv
// Multi-channel alarm: per-channel slots, lowest-index priority, and a
// ring/snooze FSM with minute-based ring timeout.
module alarm_multi
  import clock_pkg::*;
#(
  parameter int N_ALARM          = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 3,
  localparam int SEL_W           = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TIME_W-1:0]  time_in,
  input  logic [TIME_W-1:0]  time_set_in,
  input  logic [SEL_W-1:0]   set_sel,
  input  logic               set_time,
  input  logic [N_ALARM-1:0] en_in,
  input  logic               end_ring,
  input  logic               snooze,
  output logic               ring,
  output logic [SEL_W-1:0]   ring_id,
  output logic               snoozing,
  output logic               set_err
);

  localparam int CNT_W = $clog2(RING_TIMEOUT_MIN + 1);

  logic [TIME_W-1:0]  time_q;
  logic [TIME_W-1:0]  snooze_target;
  logic [CNT_W-1:0]   tmo_cnt;
  alarm_state_t       state;
  logic               minute_tick;
  logic               set_ok;
  logic [N_ALARM-1:0] match;
  logic               any_match;
  logic [SEL_W-1:0]   win_id;
  logic               id_en;

  assign minute_tick = (time_in != time_q);
  assign set_ok      = time_valid(time_set_in);

  for (genvar i = 0; i < N_ALARM; i++) begin : g_slot
    alarm_slot u_slot (
      .clk         (clk),
      .rst         (rst),
      .wr          (set_time & set_ok & (set_sel == SEL_W'(i))),
      .wdata       (time_set_in),
      .time_in     (time_in),
      .en          (en_in[i]),
      .minute_tick (minute_tick),
      .match       (match[i])
    );
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    any_match = 1'b0;
    win_id    = '0;
    id_en     = 1'b0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (match[i]) begin
        any_match = 1'b1;
        win_id    = SEL_W'(i);
      end
      if (ring_id == SEL_W'(i)) id_en = en_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q  <= '0;
      set_err <= 1'b0;
    end else begin
      time_q  <= time_in;
      set_err <= set_time & ~set_ok;
    end
  end

  // Disabling the ringing channel outranks snooze so a dead channel never arms one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ring_id       <= '0;
      tmo_cnt       <= '0;
      snooze_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_match) begin
            state   <= RING;
            ring_id <= win_id;
            tmo_cnt <= '0;
          end
        end
        RING: begin
          if (end_ring || !id_en) begin
            state <= IDLE;
          end else if (snooze) begin
            state         <= SNOOZE;
            snooze_target <= time_add_min(time_in, MIN_W'(SNOOZE_MIN));
          end else if (any_match) begin
            ring_id <= win_id;
            tmo_cnt <= '0;
          end else if (minute_tick) begin
            if (tmo_cnt == CNT_W'(RING_TIMEOUT_MIN - 1)) state <= IDLE;
            else tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        SNOOZE: begin
          if (end_ring || !id_en) begin
            state <= IDLE;
          end else if (any_match) begin
            state   <= RING;
            ring_id <= win_id;
            tmo_cnt <= '0;
          end else if (minute_tick && (time_in == snooze_target)) begin
            state   <= RING;
            tmo_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ring     = (state == RING);
  assign snoozing = (state == SNOOZE);

endmodule
